// File: rtl/ha_arb_pkg.sv
// rtl/ha_arb_pkg.sv - shared types, defaults and round-robin pick helper for the half-adder arbiter
package ha_arb_pkg;

  // Default instance sizing.
  localparam int DEF_N = 4;
  localparam int DEF_R = 4;

  // Widest requester vector the pick helper handles.
  localparam int MAX_R = 32;

  // Response buffer occupancy.
  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } ha_state_e;

  // Result of a round-robin pick: winning index and whether any request was found.
  typedef struct packed {
    logic       found;
    logic [7:0] idx;
  } rr_pick_t;

  // First set bit of valid[r-1:0], searching upward from ptr and wrapping at r.
  function automatic rr_pick_t rr_pick(input logic [MAX_R-1:0] valid,
                                       input int ptr,
                                       input int r);
    rr_pick_t res;
    int       j;
    res = '0;
    for (int k = 0; k < MAX_R; k++) begin
      if (k < r) begin
        j = ptr + k;
        if (j >= r) j = j - r;
        if (!res.found && valid[j[4:0]]) begin
          res.found = 1'b1;
          res.idx   = 8'(j);
        end
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/rr_arbiter_core.sv
// rtl/rr_arbiter_core.sv - combinational round-robin priority pick from a valid vector and pointer
module rr_arbiter_core
  import ha_arb_pkg::*;
#(
  parameter  int R   = DEF_R,
  localparam int IDW = $clog2(R)
) (
  input  logic [R-1:0]   valid,
  input  logic [IDW-1:0] ptr,
  output logic           found,
  output logic [IDW-1:0] grant
);

  rr_pick_t pick;

  // Search starts at ptr so the most recently served requester has lowest priority.
  always_comb begin
    pick  = rr_pick(MAX_R'(valid), int'(ptr), R);
    found = pick.found;
    grant = IDW'(pick.idx);
  end

endmodule

// File: rtl/ha_nbit_arbiter.sv
// rtl/ha_nbit_arbiter.sv - round-robin scheduler sharing one N-bit half-adder bank between R requesters
module ha_nbit_arbiter
  import ha_arb_pkg::*;
#(
  parameter  int N   = DEF_N,
  parameter  int R   = DEF_R,
  localparam int IDW = $clog2(R)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [R-1:0]   req_valid,
  input  logic [R*N-1:0] req_a,
  input  logic [R*N-1:0] req_b,
  output logic [R-1:0]   req_ready,
  output logic [N-1:0]   ha_a,
  output logic [N-1:0]   ha_b,
  input  logic [N-1:0]   ha_sum,
  input  logic [N-1:0]   ha_cout,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic [IDW-1:0] rsp_id,
  output logic [N-1:0]   rsp_sum,
  output logic [N-1:0]   rsp_cout
);

  ha_state_e      state;
  logic [IDW-1:0] rr_ptr;
  logic           found;
  logic [IDW-1:0] grant;
  logic           can_accept;
  logic           accept;
  logic [IDW-1:0] next_ptr;

  rr_arbiter_core #(
    .R(R)
  ) u_core (
    .valid (req_valid),
    .ptr   (rr_ptr),
    .found (found),
    .grant (grant)
  );

  // Accept when the buffer is free or is being drained this cycle; nothing is granted in reset.
  always_comb begin
    can_accept = (state == EMPTY) || rsp_ready;
    accept     = rst_n && found && can_accept;
    next_ptr   = (grant == IDW'(R - 1)) ? '0 : grant + IDW'(1);
  end

  // One-hot strobe to the winner and operand mux to the bank; idle bank inputs are held at zero.
  always_comb begin
    req_ready = '0;
    ha_a      = '0;
    ha_b      = '0;
    for (int i = 0; i < R; i++) begin
      req_ready[i] = accept && (grant == IDW'(i));
    end
    if (accept) begin
      ha_a = req_a[grant*N +: N];
      ha_b = req_b[grant*N +: N];
    end
  end

  // Response buffer, occupancy and fairness pointer; a same-edge drain and reload keeps only the new result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= EMPTY;
      rr_ptr   <= '0;
      rsp_id   <= '0;
      rsp_sum  <= '0;
      rsp_cout <= '0;
    end else if (accept) begin
      state    <= FULL;
      rr_ptr   <= next_ptr;
      rsp_id   <= grant;
      rsp_sum  <= ha_sum;
      rsp_cout <= ha_cout;
    end else if (state == FULL && rsp_ready) begin
      state <= EMPTY;
    end
  end

  assign rsp_valid = (state == FULL);

endmodule

// File: tb/tb_ha_nbit_arbiter.sv
// tb/tb_ha_nbit_arbiter.sv - directed self-checking bench for ha_nbit_arbiter
module tb_ha_nbit_arbiter;

  localparam int N   = 4;
  localparam int R   = 4;
  localparam int IDW = 2;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [R-1:0]   req_valid;
  logic [R*N-1:0] req_a;
  logic [R*N-1:0] req_b;
  logic [R-1:0]   req_ready;
  logic [N-1:0]   ha_a;
  logic [N-1:0]   ha_b;
  logic [N-1:0]   ha_sum;
  logic [N-1:0]   ha_cout;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [IDW-1:0] rsp_id;
  logic [N-1:0]   rsp_sum;
  logic [N-1:0]   rsp_cout;

  int checks   = 0;
  int failures = 0;

  // External half-adder bank.
  assign ha_sum  = ha_a ^ ha_b;
  assign ha_cout = ha_a & ha_b;

  always #5 clk = ~clk;

  ha_nbit_arbiter #(.N(N), .R(R)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .ha_a      (ha_a),
    .ha_b      (ha_b),
    .ha_sum    (ha_sum),
    .ha_cout   (ha_cout),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_sum   (rsp_sum),
    .rsp_cout  (rsp_cout)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic edge_step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_rsp(input string tag, input logic v, input logic [1:0] id,
                           input logic [3:0] s, input logic [3:0] c);
    check_eq({tag, "_valid"}, 32'(rsp_valid), 32'(v));
    check_eq({tag, "_id"},    32'(rsp_id),    32'(id));
    check_eq({tag, "_sum"},   32'(rsp_sum),   32'(s));
    check_eq({tag, "_cout"},  32'(rsp_cout),  32'(c));
  endtask

  // Requester operands: a = {9,B,5,C}, b = {F,6,3,A} for requesters {3,2,1,0}.
  // Expected: id0 sum 6 cout 8; id1 sum 6 cout 1; id2 sum D cout 2; id3 sum 6 cout 9.
  initial begin
    logic [3:0] exp_rdy [5];
    logic [1:0] exp_id  [5];
    logic [3:0] exp_sum [5];
    logic [3:0] exp_cy  [5];
    exp_rdy = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    exp_id  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    exp_sum = '{4'h6, 4'h6, 4'hD, 4'h6, 4'h6};
    exp_cy  = '{4'h8, 4'h1, 4'h2, 4'h9, 4'h8};

    req_a     = {4'h9, 4'hB, 4'h5, 4'hC};
    req_b     = {4'hF, 4'h6, 4'h3, 4'hA};
    rst_n     = 1'b0;
    req_valid = 4'b1111;
    rsp_ready = 1'b0;

    // Reset held three cycles with every requester asking.
    for (int i = 0; i < 3; i++) edge_step();
    #1;
    check_eq("rst_req_ready", 32'(req_ready), 32'h0);
    check_eq("rst_ha_a", 32'(ha_a), 32'h0);
    check_rsp("rst", 1'b0, 2'd0, 4'h0, 4'h0);

    // Release: round-robin from requester 0 with continuous consume.
    rst_n     = 1'b1;
    rsp_ready = 1'b1;
    #1;
    for (int i = 0; i < 5; i++) begin
      check_eq($sformatf("rr_ready_%0d", i), 32'(req_ready), 32'(exp_rdy[i]));
      edge_step();
      #1;
      check_rsp($sformatf("rr_rsp_%0d", i), 1'b1, exp_id[i], exp_sum[i], exp_cy[i]);
    end

    // Drain; buffer empties and the idle bank sees zeros.
    req_valid = 4'b0000;
    edge_step();
    #1;
    check_eq("drain_valid", 32'(rsp_valid), 32'h0);
    check_eq("idle_ha_b", 32'(ha_b), 32'h0);

    // Single request from requester 2 (rr_ptr now 1).
    req_valid = 4'b0100;
    #1;
    check_eq("single_ready", 32'(req_ready), 32'b0100);
    check_eq("single_ha_a", 32'(ha_a), 32'hB);
    check_eq("single_ha_b", 32'(ha_b), 32'h6);
    edge_step();
    req_valid = 4'b0000;
    #1;
    check_rsp("single", 1'b1, 2'd2, 4'hD, 4'h2);

    // Wrap and skip: rr_ptr=3 with requesters 0,1 -> grant 0 then 1.
    req_valid = 4'b0011;
    #1;
    check_eq("wrap_ready0", 32'(req_ready), 32'b0001);
    edge_step();
    #1;
    check_eq("wrap_id0", 32'(rsp_id), 32'd0);
    check_eq("wrap_ready1", 32'(req_ready), 32'b0010);
    edge_step();
    #1;
    check_rsp("wrap1", 1'b1, 2'd1, 4'h6, 4'h1);

    // Backpressure: buffer (id1) must hold for 5 cycles with no grant.
    req_valid = 4'b1111;
    rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      check_eq($sformatf("bp_ready_%0d", i), 32'(req_ready), 32'h0);
      check_rsp($sformatf("bp_%0d", i), 1'b1, 2'd1, 4'h6, 4'h1);
      edge_step();
    end

    // Release backpressure: consume and accept (id2, rr_ptr=2) on the same edge.
    rsp_ready = 1'b1;
    #1;
    check_eq("bp_release_ready", 32'(req_ready), 32'b0100);
    edge_step();
    rsp_ready = 1'b0;
    #1;
    check_rsp("bp_release", 1'b1, 2'd2, 4'hD, 4'h2);

    // Mid-operation reset while FULL and stalled.
    rst_n = 1'b0;
    edge_step();
    #1;
    check_eq("midrst_valid", 32'(rsp_valid), 32'h0);
    check_eq("midrst_ready", 32'(req_ready), 32'h0);
    rst_n = 1'b1;
    #1;
    check_eq("midrst_ptr0", 32'(req_ready), 32'b0001);
    edge_step();
    #1;
    check_rsp("midrst_first", 1'b1, 2'd0, 4'h6, 4'h8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
